cic_decim_mc: RTL and testbench

//  Parametrised multi-channel CIC decimator; successor to the fixed single-channel CIC in the 1-bit AM receive chain.

---
 rtl/cic_decim_mc.sv | 234 +++++++++++++++++++++++
 tb/tb_cic_decim_mc.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_decim_mc.sv
// ----------------------------------------------------------------------------
// cic_decim_mc
//   Multi-channel CIC decimator. NCH lanes (e.g. I and Q) are filtered in
//   lockstep and share one decimation counter, one comb valid chain and one
//   output scaling path. The integrators are pipelined: every stage adds the
//   previous stage's registered value. The comb section runs one stage per
//   clock behind the decimation tick.
//
//   Optional feature macro: CIC_SAT_EN
//     defined   : the scaled output is clamped to the OUT_W signed range, and
//                 ovf is a sticky flag that is cleared by reset or sync_clr
//     undefined : the scaled output wraps to its low OUT_W bits, ovf = 0
//
// Ports
//   CLK        in   1            clock
//   RSTb       in   1            asynchronous active-low reset
//   sync_clr   in   1            synchronous clear of all datapath state
//   in_valid   in   1            input sample strobe
//   in_data    in   NCH*IN_W     signed samples, lane 0 in the LSBs
//   dec_rate   in   RATE_W       decimation factor minus one (R-1)
//   gain_sel   in   3            output scale, right shift = SHIFT_STEP*(7-gain_sel)
//   out_valid  out  1            one-cycle output strobe
//   out_data   out  NCH*OUT_W    signed decimated samples, held between strobes
//   ovf        out  1            sticky saturation flag (CIC_SAT_EN builds only)
// ----------------------------------------------------------------------------
module cic_decim_mc #(
  parameter int NCH        = 2,
  parameter int N_STAGES   = 3,
  parameter int IN_W       = 16,
  parameter int OUT_W      = 16,
  parameter int RATE_W     = 8,
  parameter int SHIFT_STEP = 4
) (
  input  logic                  CLK,
  input  logic                  RSTb,
  input  logic                  sync_clr,
  input  logic                  in_valid,
  input  logic [NCH*IN_W-1:0]   in_data,
  input  logic [RATE_W-1:0]     dec_rate,
  input  logic [2:0]            gain_sel,
  output logic                  out_valid,
  output logic [NCH*OUT_W-1:0]  out_data,
  output logic                  ovf
);

  localparam int ACC_W = IN_W + N_STAGES * RATE_W;
  localparam int SH_W  = 8;

  // ---------------------------------------------------------------------------
  // Decimation control
  // ---------------------------------------------------------------------------
  logic [RATE_W-1:0] count;
  logic [RATE_W-1:0] rate_q;
  logic              rate_pend;
  logic [RATE_W-1:0] rate_eff;
  logic              tick;
  logic              tick_q;

  // rate_pend marks the first cycle after reset release or sync_clr. In that
  // cycle the live dec_rate is used, so R counts as latched at release even
  // when a sample arrives in that same cycle.
  assign rate_eff = rate_pend ? dec_rate : rate_q;
  assign tick     = in_valid && (count == rate_eff);

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      count     <= '0;
      rate_q    <= '0;
      rate_pend <= 1'b1;
      tick_q    <= 1'b0;
    end else if (sync_clr) begin
      count     <= '0;
      rate_q    <= '0;
      rate_pend <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      rate_pend <= 1'b0;
      tick_q    <= tick;
      if (rate_pend) rate_q <= dec_rate;
      if (in_valid) begin
        if (tick) begin
          count  <= '0;
          rate_q <= dec_rate;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Integrators (pipelined cascade, modulo 2**ACC_W)
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] integ  [NCH][N_STAGES];
  logic signed [ACC_W-1:0] int_x  [NCH][N_STAGES];
  logic signed [ACC_W-1:0] comb_c [NCH][N_STAGES];
  logic signed [ACC_W-1:0] comb_z [NCH][N_STAGES];
  logic signed [ACC_W-1:0] comb_x [NCH][N_STAGES];

  for (genvar l = 0; l < NCH; l++) begin : g_lane
    for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
        assign int_x[l][k]  = $signed({{(ACC_W-IN_W){in_data[l*IN_W+IN_W-1]}},
                                       in_data[l*IN_W +: IN_W]});
        assign comb_x[l][k] = integ[l][N_STAGES-1];
      end else begin : g_next
        assign int_x[l][k]  = integ[l][k-1];
        assign comb_x[l][k] = comb_c[l][k-1];
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      for (int l = 0; l < NCH; l++)
        for (int k = 0; k < N_STAGES; k++)
          integ[l][k] <= '0;
    end else if (sync_clr) begin
      for (int l = 0; l < NCH; l++)
        for (int k = 0; k < N_STAGES; k++)
          integ[l][k] <= '0;
    end else if (in_valid) begin
      for (int l = 0; l < NCH; l++)
        for (int k = 0; k < N_STAGES; k++)
          integ[l][k] <= integ[l][k] + int_x[l][k];
    end
  end

  // ---------------------------------------------------------------------------
  // Comb pipeline: stage k fires on vchain[k]; vchain[N_STAGES] feeds output
  // ---------------------------------------------------------------------------
  logic [N_STAGES-1:0] comb_v;
  logic [N_STAGES:0]   vchain;

  assign vchain = {comb_v, tick_q};

  // Stage 0 reads integ directly one cycle after the tick. At that point integ
  // still holds the value produced by the ticking sample, because any newer
  // sample lands on the same edge that the comb stage samples.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      comb_v <= '0;
      for (int l = 0; l < NCH; l++)
        for (int k = 0; k < N_STAGES; k++) begin
          comb_c[l][k] <= '0;
          comb_z[l][k] <= '0;
        end
    end else if (sync_clr) begin
      comb_v <= '0;
      for (int l = 0; l < NCH; l++)
        for (int k = 0; k < N_STAGES; k++) begin
          comb_c[l][k] <= '0;
          comb_z[l][k] <= '0;
        end
    end else begin
      comb_v <= vchain[N_STAGES-1:0];
      for (int l = 0; l < NCH; l++)
        for (int k = 0; k < N_STAGES; k++)
          if (vchain[k]) begin
            comb_c[l][k] <= comb_x[l][k] - comb_z[l][k];
            comb_z[l][k] <= comb_x[l][k];
          end
    end
  end

  // ---------------------------------------------------------------------------
  // Output scaling
  // ---------------------------------------------------------------------------
  logic [SH_W-1:0]  shamt;
  logic [OUT_W-1:0] lane_out [NCH];

  assign shamt = SH_W'(SHIFT_STEP) * SH_W'(3'd7 - gain_sel);

`ifdef CIC_SAT_EN
  localparam logic signed [ACC_W-1:0] Y_MAX =
    $signed({{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] Y_MIN =
    $signed({{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});

  logic signed [ACC_W-1:0] y_sh [NCH];
  logic                    sat_hit;
  logic                    ovf_q;

  always_comb begin
    sat_hit = 1'b0;
    for (int l = 0; l < NCH; l++) begin
      y_sh[l]     = comb_c[l][N_STAGES-1] >>> shamt;
      lane_out[l] = y_sh[l][OUT_W-1:0];
      if (y_sh[l] > Y_MAX) begin
        lane_out[l] = Y_MAX[OUT_W-1:0];
        sat_hit     = 1'b1;
      end else if (y_sh[l] < Y_MIN) begin
        lane_out[l] = Y_MIN[OUT_W-1:0];
        sat_hit     = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      ovf_q <= 1'b0;
    end else if (sync_clr) begin
      ovf_q <= 1'b0;
    end else if (vchain[N_STAGES] && sat_hit) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  always_comb begin
    for (int l = 0; l < NCH; l++)
      lane_out[l] = OUT_W'(comb_c[l][N_STAGES-1] >>> shamt);
  end

  assign ovf = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (sync_clr) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= vchain[N_STAGES];
      if (vchain[N_STAGES])
        for (int l = 0; l < NCH; l++)
          out_data[l*OUT_W +: OUT_W] <= lane_out[l];
    end
  end

endmodule

// File: tb/tb_cic_decim_mc.sv
module tb_cic_decim_mc;

  localparam int NCH    = 2;
  localparam int NS     = 3;
  localparam int IN_W   = 16;
  localparam int OUT_W  = 16;
  localparam int RATE_W = 8;
  localparam int ACC_W  = IN_W + NS * RATE_W;

  logic                 CLK = 1'b0;
  logic                 RSTb;
  logic                 sync_clr;
  logic                 in_valid;
  logic [NCH*IN_W-1:0]  in_data;
  logic [RATE_W-1:0]    dec_rate;
  logic [2:0]           gain_sel;
  logic                 out_valid;
  logic [NCH*OUT_W-1:0] out_data;
  logic                 ovf;

  cic_decim_mc #(
    .NCH(NCH), .N_STAGES(NS), .IN_W(IN_W), .OUT_W(OUT_W),
    .RATE_W(RATE_W), .SHIFT_STEP(4)
  ) dut (
    .CLK(CLK), .RSTb(RSTb), .sync_clr(sync_clr), .in_valid(in_valid),
    .in_data(in_data), .dec_rate(dec_rate), .gain_sel(gain_sel),
    .out_valid(out_valid), .out_data(out_data), .ovf(ovf)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int ec = 0;
  int n_seen = 0;
  int last0, last1;
  int out_edges[$];

  typedef struct {int due; int v0; int v1;} exp_t;
  exp_t sbq[$];

  typedef struct {
    int rate; int gain; int d0; int d1; int vper; int nout;
    int e0; int e1; int eovf;
  } vec_t;
  vec_t tbl[8];

  // Sample-level reference model
  logic signed [ACC_W-1:0] mi [NCH][NS];
  logic signed [ACC_W-1:0] mz [NCH][NS];
  int m_cnt, m_rate;
  bit m_pend, m_ovf;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ec);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at edge %0d", name, ec);
  endtask

  task automatic mdl_out(input logic signed [ACC_W-1:0] c, input int gain, output int v);
    logic signed [ACC_W-1:0] y;
    y = c >>> (4 * (7 - gain));
`ifdef CIC_SAT_EN
    if (y > 32767) begin
      v = 32767; m_ovf = 1'b1;
    end else if (y < -32768) begin
      v = -32768; m_ovf = 1'b1;
    end else begin
      v = int'(y);
    end
`else
    begin
      logic [OUT_W-1:0] lo;
      lo = y[OUT_W-1:0];
      v = int'($signed(lo));
    end
`endif
  endtask

  task automatic mdl_edge(input bit clr, input bit vld, input int d0, input int d1,
                          input int rate, input int gain, input int edge_no);
    int r_eff;
    int v [NCH];
    logic signed [IN_W-1:0]  t;
    logic signed [ACC_W-1:0] x, c;
    exp_t e;
    if (clr) begin
      for (int l = 0; l < NCH; l++)
        for (int k = 0; k < NS; k++) begin
          mi[l][k] = '0; mz[l][k] = '0;
        end
      m_cnt = 0; m_rate = 0; m_pend = 1'b1; m_ovf = 1'b0;
      sbq.delete();
      return;
    end
    r_eff = m_pend ? rate : m_rate;
    if (m_pend) m_rate = rate;
    m_pend = 1'b0;
    if (!vld) return;
    for (int l = 0; l < NCH; l++) begin
      t = (l == 0) ? IN_W'(d0) : IN_W'(d1);
      x = t;
      for (int k = NS - 1; k >= 1; k--) mi[l][k] = mi[l][k] + mi[l][k-1];
      mi[l][0] = mi[l][0] + x;
    end
    if (m_cnt == r_eff) begin
      m_cnt = 0;
      m_rate = rate;
      for (int l = 0; l < NCH; l++) begin
        x = mi[l][NS-1];
        for (int k = 0; k < NS; k++) begin
          c = x - mz[l][k];
          mz[l][k] = x;
          x = c;
        end
        mdl_out(x, gain, v[l]);
      end
      e.due = edge_no + NS + 1;
      e.v0 = v[0];
      e.v1 = v[1];
      sbq.push_back(e);
    end else begin
      m_cnt++;
    end
  endtask

  task automatic check_out();
    exp_t e;
    while (sbq.size() > 0 && sbq[0].due < ec) begin
      fail_now($sformatf("out_valid_missing due %0d", sbq[0].due));
      e = sbq.pop_front();
    end
    if (out_valid) begin
      if (sbq.size() == 0) begin
        fail_now("out_valid_spurious");
      end else begin
        e = sbq.pop_front();
        last0 = int'($signed(out_data[OUT_W-1:0]));
        last1 = int'($signed(out_data[2*OUT_W-1:OUT_W]));
        chk("latency", ec, e.due);
        chk("lane0", last0, e.v0);
        chk("lane1", last1, e.v1);
        out_edges.push_back(ec);
        n_seen++;
      end
    end
  endtask

  task automatic step(input bit vld, input int d0, input int d1);
    logic [IN_W-1:0] a0, a1;
    a0 = IN_W'(d0);
    a1 = IN_W'(d1);
    in_valid = vld;
    in_data  = {a1, a0};
    mdl_edge(sync_clr || !RSTb, vld, d0, d1, int'(dec_rate), int'(gain_sel), ec + 1);
    @(posedge CLK);
    #1;
    ec++;
    check_out();
  endtask

  task automatic run_until(input int nout, input int budget, input int d0, input int d1);
    int i;
    i = 0;
    while (n_seen < nout && i < budget) begin
      step(1'b1, d0, d1);
      i++;
    end
    if (n_seen < nout) fail_now("timeout_waiting_out_valid");
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int i, budget;
    dec_rate = RATE_W'(v.rate);
    gain_sel = 3'(v.gain);
    sync_clr = 1'b1;
    step(1'b1, v.d0, v.d1);
    sync_clr = 1'b0;
    chk($sformatf("vec%0d_clr_out_valid", idx), int'(out_valid), 0);
    n_seen = 0;
    out_edges.delete();
    i = 0;
    budget = v.nout * (v.rate + 1) * v.vper + 40;
    while (n_seen < v.nout && i < budget) begin
      step((i % v.vper) == 0, v.d0, v.d1);
      i++;
    end
    in_valid = 1'b0;
    if (n_seen < v.nout) fail_now($sformatf("vec%0d_timeout", idx));
    chk($sformatf("vec%0d_settled_lane0", idx), last0, v.e0);
    chk($sformatf("vec%0d_settled_lane1", idx), last1, v.e1);
    if (out_edges.size() >= 2)
      chk($sformatf("vec%0d_period", idx),
          out_edges[out_edges.size()-1] - out_edges[out_edges.size()-2],
          (v.rate + 1) * v.vper);
    chk($sformatf("vec%0d_ovf", idx), int'(ovf), v.eovf);
  endtask

  initial begin
    int e8;

    //          rate gain   d0     d1  vper nout    e0      e1   ovf
    tbl[0] = '{   7,   6,  1000,  1000, 1, 6,  32000,  32000, 0};
    tbl[2] = '{   7,   6,  1000, -1000, 1, 6,  32000, -32000, 0};
    tbl[3] = '{   7,   6,  1000,  1000, 3, 6,  32000,  32000, 0};
    tbl[4] = '{   3,   6,  1000,  1000, 1, 6,   4000,   4000, 0};
    tbl[5] = '{   0,   7,  1000,    -1, 1, 6,   1000,     -1, 0};
    tbl[7] = '{ 255,   0,  1000, -1000, 1, 5,     62,    -63, 0};
`ifdef CIC_SAT_EN
    tbl[1] = '{   7,   7,  1000,  1000, 1, 6,  32767,  32767, 1};
    tbl[6] = '{   7,   7, -1000,   500, 1, 6, -32768,  32767, 1};
`else
    tbl[1] = '{   7,   7,  1000,  1000, 1, 6, -12288, -12288, 0};
    tbl[6] = '{   7,   7, -1000,   500, 1, 6,  12288,  -6144, 0};
`endif

    RSTb = 1'b0; sync_clr = 1'b0; in_valid = 1'b0; in_data = '0;
    dec_rate = 8'd7; gain_sel = 3'd6;
    #2;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_ovf", int'(ovf), 0);
    step(1'b0, 0, 0);
    step(1'b0, 0, 0);
    RSTb = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

    // Rate change mid-frame: 7 -> 3 after 12 samples
    dec_rate = 8'd7; gain_sel = 3'd6;
    sync_clr = 1'b1;
    step(1'b1, 1000, 1000);
    sync_clr = 1'b0;
    n_seen = 0;
    out_edges.delete();
    for (int i = 0; i < 12; i++) step(1'b1, 1000, 1000);
    dec_rate = 8'd3;
    run_until(8, 80, 1000, 1000);
    if (out_edges.size() >= 3) begin
      chk("rc_frame_completes_at_8", out_edges[1] - out_edges[0], 8);
      chk("rc_new_period_4", out_edges[2] - out_edges[1], 4);
    end else begin
      fail_now("rc_too_few_outputs");
    end
    chk("rc_settled_lane0", last0, 4000);
    chk("rc_settled_lane1", last1, 4000);

    // Asynchronous reset mid-frame
    dec_rate = 8'd7;
    step(1'b1, 1000, 1000);
    step(1'b1, 1000, 1000);
    #3;
    RSTb = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_data", int'(out_data), 0);
    chk("arst_ovf", int'(ovf), 0);
    step(1'b1, 1000, 1000);
    step(1'b1, 1000, 1000);
    RSTb = 1'b1;
    n_seen = 0;
    out_edges.delete();
    e8 = ec + 8;
    run_until(4, 60, 1000, 1000);
    if (out_edges.size() >= 1) chk("arst_first_out_edge", out_edges[0], e8 + NS + 1);

    // Synchronous clear mid-frame, coinciding with in_valid
    step(1'b1, 1000, 1000);
    step(1'b1, 1000, 1000);
    step(1'b1, 1000, 1000);
    sync_clr = 1'b1;
    step(1'b1, 1000, 1000);
    sync_clr = 1'b0;
    chk("sclr_out_valid", int'(out_valid), 0);
    chk("sclr_out_data", int'(out_data), 0);
    n_seen = 0;
    out_edges.delete();
    e8 = ec + 8;
    run_until(1, 40, 1000, 1000);
    if (out_edges.size() >= 1) chk("sclr_first_out_edge", out_edges[0], e8 + NS + 1);

    in_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
